// File: rtl/baud_tick_gen.sv
// UART baud-tick generator: fractional int.frac divider producing single-cycle
// oversample, mid-bit and bit-end enable pulses, all on the system clock.
module baud_tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned FRAC_BITS   = 4,
  localparam int unsigned PW         = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 cfg_mode,
  input  logic [1:0]           baud_sel,
  input  logic [DIV_W-1:0]     div_int,
  input  logic [FRAC_BITS-1:0] div_frac,
  output logic                 os_tick,
  output logic                 mid_tick,
  output logic                 bit_tick,
  output logic [PW-1:0]        os_phase
);

  localparam int unsigned DW = DIV_W + FRAC_BITS;

  // Fixed-point divisor {int,frac} = round(clk * 2^FRAC_BITS / (OVERSAMPLE * baud))
  function automatic logic [DW-1:0] preset_div(input longint unsigned baud);
    longint unsigned num;
    longint unsigned den;
    num = longint'(CLK_FREQ_HZ) << FRAC_BITS;
    den = longint'(OVERSAMPLE) * baud;
    return DW'((num + den / 2) / den);
  endfunction

  localparam logic [DW-1:0] PRESET_2400  = preset_div(2400);
  localparam logic [DW-1:0] PRESET_4800  = preset_div(4800);
  localparam logic [DW-1:0] PRESET_9600  = preset_div(9600);
  localparam logic [DW-1:0] PRESET_19200 = preset_div(19200);

  logic [DW-1:0]        sel_div;
  logic [DIV_W-1:0]     sel_int_raw;
  logic [DIV_W-1:0]     sel_int;
  logic [FRAC_BITS-1:0] sel_frac;

  logic [DIV_W-1:0]     cnt;
  logic [FRAC_BITS-1:0] acc;
  logic [FRAC_BITS-1:0] shadow_frac;
  logic                 en_q;

  logic                 load;
  logic                 expire;
  logic                 carry;
  logic [FRAC_BITS-1:0] acc_sum;
  logic                 phase_last;
  logic                 phase_mid;

  // Select the divisor source and clamp the integer part to at least 2
  always_comb begin
    sel_div = PRESET_2400;
    if (cfg_mode) begin
      sel_div = {div_int, div_frac};
    end else begin
      case (baud_sel)
        2'b00:   sel_div = PRESET_2400;
        2'b01:   sel_div = PRESET_4800;
        2'b10:   sel_div = PRESET_9600;
        default: sel_div = PRESET_19200;
      endcase
    end
    sel_int_raw = sel_div[DW-1:FRAC_BITS];
    sel_frac    = sel_div[FRAC_BITS-1:0];
    sel_int     = (sel_int_raw < DIV_W'(2)) ? DIV_W'(2) : sel_int_raw;
  end

  // Load detection, fractional accumulate and phase decode
  always_comb begin
    load             = en & (~en_q | sync);
    expire           = (cnt == '0);
    {carry, acc_sum} = {1'b0, acc} + {1'b0, shadow_frac};
    phase_last       = (os_phase == PW'(OVERSAMPLE - 1));
    phase_mid        = (os_phase == PW'(OVERSAMPLE / 2 - 1));
  end

  // Divider counter, fractional accumulator, phase index and registered ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      os_phase    <= '0;
      os_tick     <= 1'b0;
      mid_tick    <= 1'b0;
      bit_tick    <= 1'b0;
      shadow_frac <= PRESET_2400[FRAC_BITS-1:0];
      en_q        <= 1'b0;
    end else begin
      en_q     <= en;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      if (load) begin
        shadow_frac <= sel_frac;
        cnt         <= sel_int - DIV_W'(1);
        acc         <= '0;
        os_phase    <= '0;
      end else if (en) begin
        if (!expire) begin
          cnt <= cnt - DIV_W'(1);
        end else begin
          // Carry comes from the outgoing fraction; the new config takes over from here
          acc         <= acc_sum;
          shadow_frac <= sel_frac;
          cnt         <= sel_int - DIV_W'(1) + DIV_W'(carry);
          os_phase    <= phase_last ? '0 : os_phase + PW'(1);
          os_tick     <= 1'b1;
          mid_tick    <= phase_mid;
          bit_tick    <= phase_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at 50 MHz, 16x oversample, 16.4 divisor.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        rst, en, sync, cfg_mode;
  logic [1:0]  baud_sel;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick, mid_tick, bit_tick;
  logic [3:0]  os_phase;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .CLK_FREQ_HZ(50_000_000),
    .OVERSAMPLE (16),
    .DIV_W      (16),
    .FRAC_BITS  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .cfg_mode(cfg_mode),
    .baud_sel(baud_sel),
    .div_int (div_int),
    .div_frac(div_frac),
    .os_tick (os_tick),
    .mid_tick(mid_tick),
    .bit_tick(bit_tick),
    .os_phase(os_phase)
  );

  task step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Step until os_tick (or bit_tick) is seen, bounded by budget cycles
  task automatic wait_sig(input string tag, input bit use_bit, input int budget, output int at);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (((use_bit ? bit_tick : os_tick) !== 1'b1) && n < budget);
    check({tag, "_seen"}, 32'(use_bit ? bit_tick : os_tick), 1);
    at = cyc;
  endtask

  task automatic sync_load(output int l);
    sync = 1'b1;
    step();
    l = cyc;
    sync = 1'b0;
  endtask

  initial begin
    int l, t0, t1, t2, sum, quiet;
    int gap_exp [4];
    int first_bit [4];
    real baud_hz [4];
    real e;

    gap_exp   = '{3, 4, 3, 4};
    first_bit = '{20832, 10416, 5207, 2603};
    baud_hz   = '{2400.0, 4800.0, 9600.0, 19200.0};

    rst = 1'b1; en = 1'b1; sync = 1'b0; cfg_mode = 1'b0;
    baud_sel = 2'b00; div_int = '0; div_frac = '0;

    // Reset held with en=1
    for (int i = 0; i < 3; i++) step();
    check("rst_os", 32'(os_tick), 0);
    check("rst_mid", 32'(mid_tick), 0);
    check("rst_bit", 32'(bit_tick), 0);
    check("rst_phase", 32'(os_phase), 0);

    // Preset 2400: os period 1302 (frac 1/16)
    rst = 1'b0;
    step();
    l = cyc;
    check("load_quiet", 32'(os_tick), 0);
    wait_sig("p2400_t1", 1'b0, 2000, t0);
    check("p2400_first", 32'(t0 - l), 1302);
    check("p2400_phase1", 32'(os_phase), 1);
    wait_sig("p2400_t2", 1'b0, 2000, t1);
    check("p2400_gap", 32'(t1 - t0), 1302);
    check("p2400_phase2", 32'(os_phase), 2);

    // Fractional 3 + 8/16
    cfg_mode = 1'b1; div_int = 16'd3; div_frac = 4'd8;
    sync_load(l);
    wait_sig("frac_t1", 1'b0, 20, t0);
    check("frac_first", 32'(t0 - l), 3);
    sum = 0;
    for (int k = 0; k < 32; k++) begin
      wait_sig("frac_tn", 1'b0, 20, t1);
      if (k < 4) check("frac_gap", 32'(t1 - t0), 32'(gap_exp[k]));
      sum += t1 - t0;
      t0 = t1;
    end
    check("frac_sum32", 32'(sum), 112);

    // Phase decode with int=2
    div_int = 16'd2; div_frac = 4'd0;
    sync_load(l);
    for (int k = 1; k <= 16; k++) begin
      wait_sig("ph_t", 1'b0, 10, t0);
      check("ph_phase", 32'(os_phase), 32'(k % 16));
      check("ph_mid", 32'(mid_tick), 32'(k == 8));
      check("ph_bit", 32'(bit_tick), 32'(k == 16));
      if (k == 1) check("ph_first", 32'(t0 - l), 2);
    end
    wait_sig("ph_bit2", 1'b1, 40, t1);
    check("ph_bit_period", 32'(t1 - t0), 32);

    // Sync: restart mid-period
    div_int = 16'd7;
    sync_load(l);
    wait_sig("sy_t0", 1'b0, 20, t0);
    check("sy_first", 32'(t0 - l), 7);
    for (int i = 0; i < 4; i++) step();
    sync_load(l);
    check("sy_quiet", 32'(os_tick), 0);
    check("sy_phase0", 32'(os_phase), 0);
    wait_sig("sy_t1", 1'b0, 20, t1);
    check("sy_after", 32'(t1 - l), 7);
    check("sy_phase1", 32'(os_phase), 1);
    // Sync coincident with cnt==0 suppresses the tick
    for (int i = 0; i < 6; i++) step();
    sync_load(l);
    check("sy_coinc_quiet", 32'(os_tick), 0);
    wait_sig("sy_t2", 1'b0, 20, t2);
    check("sy_coinc_after", 32'(t2 - l), 7);
    // Back-to-back sync
    sync = 1'b1;
    for (int i = 0; i < 3; i++) step();
    l = cyc;
    sync = 1'b0;
    wait_sig("sy_b2b", 1'b0, 20, t0);
    check("sy_b2b_after", 32'(t0 - l), 7);

    // Gating: drop en on the cycle the next tick would fire
    for (int i = 0; i < 6; i++) step();
    en = 1'b0;
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (os_tick || mid_tick || bit_tick) quiet++;
    end
    check("gate_quiet", 32'(quiet), 0);
    check("gate_phase_hold", 32'(os_phase), 1);
    en = 1'b1;
    step();
    l = cyc;
    wait_sig("gate_t", 1'b0, 20, t0);
    check("gate_reload", 32'(t0 - l), 7);
    check("gate_phase", 32'(os_phase), 1);

    // Config change mid-period takes effect at the next boundary
    div_int = 16'd5;
    sync_load(l);
    wait_sig("cfg_t0", 1'b0, 20, t0);
    check("cfg_first5", 32'(t0 - l), 5);
    step(); step();
    div_int = 16'd9;
    wait_sig("cfg_t1", 1'b0, 20, t1);
    check("cfg_cur5", 32'(t1 - t0), 5);
    wait_sig("cfg_t2", 1'b0, 20, t2);
    check("cfg_next9", 32'(t2 - t1), 9);

    // int 0 and 1 clamp to 2
    for (int v = 0; v < 2; v++) begin
      div_int = 16'(v);
      sync_load(l);
      wait_sig("clamp_t0", 1'b0, 10, t0);
      check("clamp_first", 32'(t0 - l), 2);
      wait_sig("clamp_t1", 1'b0, 10, t1);
      check("clamp_gap", 32'(t1 - t0), 2);
    end

    // Presets: first bit after load and rate error
    cfg_mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      baud_sel = 2'(s);
      sync_load(l);
      wait_sig("pre_bit", 1'b1, 25000, t0);
      check("pre_first_bit", 32'(t0 - l), 32'(first_bit[s]));
      e = real'(t0 - l) - 50.0e6 / baud_hz[s];
      if (e < 0.0) e = -e;
      check("pre_err", 32'((e / (50.0e6 / baud_hz[s])) < 0.001), 1);
      if (s >= 2) begin
        wait_sig("pre_bit2", 1'b1, 6000, t1);
        check("pre_bit_period", 32'(t1 - t0), (s == 2) ? 32'd5208 : 32'd2604);
      end
    end

    // Reset mid-run
    rst = 1'b1;
    step();
    check("rst_mid_os", 32'(os_tick), 0);
    check("rst_mid_phase", 32'(os_phase), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
